ds_pixel_arbiter: RTL

- Launches and drains NUM_OPS diamond-square single-operator instances, each producing one DIM x DIM tile.
- Once an operator raises done, it streams pixels through an ack-driven handshake: one ack per pixel, x/y/z valid a fixed number of cycles later.
- This block round-robins those streams onto one shared pixel-write port toward the VGA/SDRAM writer.
- Each tile coordinate is offset to its screen origin before the write.

---
 rtl/ds_pkg.sv | 15 +
 rtl/ds_rr_pick.sv | 22 ++
 rtl/ds_pixel_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ds_pkg.sv
// Shared types and helpers for the diamond-square pixel arbiter.
package ds_pkg;
    localparam int COORD_W           = 10;
    localparam int Z_W               = 8;
    localparam int CAPTURE_DELAY_DEF = 3;

    typedef enum logic [2:0] {
        IDLE, LAUNCH, SELECT, ACK, WAIT, CAPTURE, EMIT, DONE
    } ds_state_e;

    // Screen origin of tile k along one axis, wrapped to the coordinate width.
    function automatic logic [COORD_W-1:0] tile_origin(input int base, input int k, input int dim);
        return COORD_W'(base + k * dim);
    endfunction
endpackage

// File: rtl/ds_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module ds_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);
    // Scan from the far end so the closest request to ptr is written last.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) begin
                idx_o   = W'((int'(ptr_i) + k) % N);
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ds_pixel_arbiter.sv
// Round-robin drain of NUM_OPS diamond-square tiles onto one pixel-write port,
// one pixel per grant, with each tile offset to its screen origin.
module ds_pixel_arbiter import ds_pkg::*; #(
    parameter int  NUM_OPS       = 4,
    parameter int  DIM           = 9,
    parameter int  TILE_COLS     = 2,
    parameter int  X_BASE        = 0,
    parameter int  Y_BASE        = 0,
    parameter int  CAPTURE_DELAY = CAPTURE_DELAY_DEF,
    localparam int GW            = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_OPS-1:0]     op_done,
    input  logic [NUM_OPS*10-1:0]  op_x,
    input  logic [NUM_OPS*10-1:0]  op_y,
    input  logic [NUM_OPS*8-1:0]   op_z,
    output logic [NUM_OPS-1:0]     op_ack,
    output logic                   op_reset,
    output logic [9:0]             pix_x,
    output logic [9:0]             pix_y,
    output logic [7:0]             pix_color,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [GW-1:0]          grant_id,
    output logic                   busy,
    output logic                   all_done,
    output logic                   error
);
    localparam int NPIX = DIM * DIM;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int TW   = (CAPTURE_DELAY > 1) ? $clog2(CAPTURE_DELAY) : 1;

    ds_state_e                   state_q, state_d;
    logic [GW-1:0]               grant_q, grant_d, rr_q, rr_d;
    logic [TW-1:0]               timer_q, timer_d;
    logic [NUM_OPS-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [NUM_OPS-1:0]          cmpl_q, cmpl_d, ack_q, ack_d;
    logic [COORD_W-1:0]          px_q, px_d, py_q, py_d;
    logic [Z_W-1:0]              pc_q, pc_d;
    logic                        valid_q, valid_d, error_q, error_d;
    logic                        op_reset_q, busy_q, all_done_q;

    logic [NUM_OPS-1:0][COORD_W-1:0] org_x, org_y;
    for (genvar g = 0; g < NUM_OPS; g++) begin : g_org
        assign org_x[g] = tile_origin(X_BASE, g % TILE_COLS, DIM);
        assign org_y[g] = tile_origin(Y_BASE, g / TILE_COLS, DIM);
    end

    logic [GW-1:0] pick_idx;
    logic          pick_found;
    ds_rr_pick #(.N(NUM_OPS), .W(GW)) u_pick (
        .req_i   (op_done & ~cmpl_q),
        .ptr_i   (rr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    logic [COORD_W-1:0] sel_x, sel_y;
    logic [Z_W-1:0]     sel_z;
    assign sel_x = op_x[int'(grant_q)*COORD_W +: COORD_W];
    assign sel_y = op_y[int'(grant_q)*COORD_W +: COORD_W];
    assign sel_z = op_z[int'(grant_q)*Z_W +: Z_W];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        cmpl_d  = cmpl_q;
        ack_d   = '0;
        px_d    = px_q;
        py_d    = py_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        error_d = error_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LAUNCH;
                    cnt_d   = '0;
                    cmpl_d  = '0;
                    error_d = 1'b0;
                end
            end
            LAUNCH: state_d = SELECT;
            SELECT: begin
                if (pick_found) begin
                    grant_d         = pick_idx;
                    ack_d[pick_idx] = 1'b1;
                    state_d         = ACK;
                end else if (&cmpl_q) begin
                    state_d = DONE;
                end
            end
            ACK: begin
                timer_d = TW'(CAPTURE_DELAY - 1);
                state_d = (CAPTURE_DELAY > 1) ? WAIT : CAPTURE;
            end
            WAIT: begin
                if (timer_q <= TW'(1)) state_d = CAPTURE;
                else                    timer_d = timer_q - TW'(1);
            end
            CAPTURE: begin
                px_d    = org_x[grant_q] + sel_x;
                py_d    = org_y[grant_q] + sel_y;
                pc_d    = sel_z;
                valid_d = 1'b1;
                // Out-of-tile coordinates or a dropped done are flagged, but the pixel still goes out.
                if (sel_x >= COORD_W'(DIM) || sel_y >= COORD_W'(DIM) || !op_done[grant_q])
                    error_d = 1'b1;
                state_d = EMIT;
            end
            EMIT: begin
                if (pix_ready) begin
                    valid_d        = 1'b0;
                    cnt_d[grant_q] = cnt_q[grant_q] + CW'(1);
                    if (cnt_q[grant_q] == CW'(NPIX - 1)) cmpl_d[grant_q] = 1'b1;
                    rr_d    = (grant_q == GW'(NUM_OPS - 1)) ? '0 : grant_q + GW'(1);
                    state_d = SELECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_q       <= '0;
            timer_q    <= '0;
            cnt_q      <= '0;
            cmpl_q     <= '0;
            ack_q      <= '0;
            px_q       <= '0;
            py_q       <= '0;
            pc_q       <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            op_reset_q <= 1'b1;
            busy_q     <= 1'b0;
            all_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            cmpl_q     <= cmpl_d;
            ack_q      <= ack_d;
            px_q       <= px_d;
            py_q       <= py_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            op_reset_q <= (state_d == IDLE) || (state_d == LAUNCH);
            busy_q     <= !((state_d == IDLE) || (state_d == DONE));
            all_done_q <= (state_d == DONE);
        end
    end

    assign op_ack    = ack_q;
    assign op_reset  = op_reset_q;
    assign pix_x     = px_q;
    assign pix_y     = py_q;
    assign pix_color = pc_q;
    assign pix_valid = valid_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign all_done  = all_done_q;
    assign error     = error_q;
endmodule
